// File: rtl/ifu_fetch_if.sv
// Instruction bus between the fetch stage (master) and the memory/bus slave.
// Strobe and ready are active-low; read data is valid while if_rdy_ is low.
`timescale 1ns/1ps
interface ifu_fetch_if;
    logic [29:0] if_addr;
    logic        if_as_;
    logic [31:0] if_rd_data;
    logic        if_rdy_;

    modport master (
        output if_addr,
        output if_as_,
        input  if_rd_data,
        input  if_rdy_
    );

    modport slave (
        input  if_addr,
        input  if_as_,
        output if_rd_data,
        output if_rdy_
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: fetch PC, stall-tolerant bus handshake and IF/ID register.
// Optional fetch timeout pulse on if_bus_err is built only when IFU_BUS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ifu_fetch #(
    parameter logic [29:0] RESET_VECTOR   = 30'h0,
    parameter logic [31:0] NOP_INSN       = 32'h0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [29:0] new_pc,
    input  logic        br_taken,
    input  logic [29:0] br_addr,
    ifu_fetch_if.master bus,
    output logic [29:0] if_pc,
    output logic [31:0] if_insn,
    output logic        if_en,
    output logic        if_bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [29:0] fetch_pc_reg, fetch_pc_next;
    logic [29:0] if_pc_reg, if_pc_next;
    logic [31:0] if_insn_reg, if_insn_next;
    logic        if_en_reg, if_en_next;
    logic        hold_valid_reg, hold_valid_next;
    logic [29:0] hold_pc_reg, hold_pc_next;
    logic [31:0] hold_insn_reg, hold_insn_next;
    logic        br_pend_reg, br_pend_next;
    logic [29:0] br_pend_addr_reg, br_pend_addr_next;
    logic [29:0] drain_addr_reg, drain_addr_next;
    logic        as_n;
    logic [29:0] addr;
    logic        pending;
    logic        complete;
    logic [29:0] next_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= S_IDLE;
            fetch_pc_reg     <= RESET_VECTOR;
            if_pc_reg        <= RESET_VECTOR;
            if_insn_reg      <= NOP_INSN;
            if_en_reg        <= 1'b0;
            hold_valid_reg   <= 1'b0;
            hold_pc_reg      <= RESET_VECTOR;
            hold_insn_reg    <= NOP_INSN;
            br_pend_reg      <= 1'b0;
            br_pend_addr_reg <= RESET_VECTOR;
            drain_addr_reg   <= RESET_VECTOR;
        end else begin
            state_reg        <= state_next;
            fetch_pc_reg     <= fetch_pc_next;
            if_pc_reg        <= if_pc_next;
            if_insn_reg      <= if_insn_next;
            if_en_reg        <= if_en_next;
            hold_valid_reg   <= hold_valid_next;
            hold_pc_reg      <= hold_pc_next;
            hold_insn_reg    <= hold_insn_next;
            br_pend_reg      <= br_pend_next;
            br_pend_addr_reg <= br_pend_addr_next;
            drain_addr_reg   <= drain_addr_next;
        end
    end

    // An access is outstanding in S_FETCH whenever no stalled word is parked in the hold slot.
    assign pending  = (state_reg == S_FETCH) && !hold_valid_reg && bus.if_rdy_;
    assign complete = (state_reg == S_FETCH) && !hold_valid_reg && !bus.if_rdy_;

    always_comb begin
        if (br_taken && !stall)
            next_pc = br_addr;
        else if (br_pend_reg)
            next_pc = br_pend_addr_reg;
        else
            next_pc = fetch_pc_reg + 30'd1;
    end

    always_comb begin
        state_next        = state_reg;
        fetch_pc_next     = fetch_pc_reg;
        if_pc_next        = if_pc_reg;
        if_insn_next      = if_insn_reg;
        if_en_next        = if_en_reg;
        hold_valid_next   = hold_valid_reg;
        hold_pc_next      = hold_pc_reg;
        hold_insn_next    = hold_insn_reg;
        br_pend_next      = br_pend_reg;
        br_pend_addr_next = br_pend_addr_reg;
        drain_addr_next   = drain_addr_reg;
        as_n              = 1'b1;
        addr              = fetch_pc_reg;
        unique case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH;
                if (flush)
                    fetch_pc_next = new_pc;
            end
            S_FETCH: begin
                as_n = hold_valid_reg;
                if (flush) begin
                    fetch_pc_next   = new_pc;
                    if_en_next      = 1'b0;
                    if_insn_next    = NOP_INSN;
                    hold_valid_next = 1'b0;
                    br_pend_next    = 1'b0;
                    // A strobed access cannot be abandoned; finish it and drop the data.
                    if (pending) begin
                        drain_addr_next = fetch_pc_reg;
                        state_next      = S_DRAIN;
                    end
                end else begin
                    if (hold_valid_reg && !stall) begin
                        if_pc_next      = hold_pc_reg;
                        if_insn_next    = hold_insn_reg;
                        if_en_next      = 1'b1;
                        hold_valid_next = 1'b0;
                    end else if (complete && stall) begin
                        hold_pc_next    = fetch_pc_reg;
                        hold_insn_next  = bus.if_rd_data;
                        hold_valid_next = 1'b1;
                    end else if (complete) begin
                        if_pc_next   = fetch_pc_reg;
                        if_insn_next = bus.if_rd_data;
                        if_en_next   = 1'b1;
                    end else if (!stall) begin
                        if_en_next   = 1'b0;
                        if_insn_next = NOP_INSN;
                    end
                    // A completing fetch is the delay slot; otherwise remember the target.
                    if (complete) begin
                        fetch_pc_next = next_pc;
                        br_pend_next  = 1'b0;
                    end else if (br_taken && !stall) begin
                        br_pend_next      = 1'b1;
                        br_pend_addr_next = br_addr;
                    end
                end
            end
            S_DRAIN: begin
                as_n       = 1'b0;
                addr       = drain_addr_reg;
                if_en_next = 1'b0;
                if (flush)
                    fetch_pc_next = new_pc;
                if (!bus.if_rdy_)
                    state_next = S_FETCH;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.if_as_   = as_n;
    assign bus.if_addr  = addr;
    assign if_pc        = if_pc_reg;
    assign if_insn      = if_insn_reg;
    assign if_en        = if_en_reg;

`ifdef IFU_BUS_TIMEOUT_EN
    logic [31:0] wait_cnt_reg, wait_cnt_next;
    logic        bus_err;

    // Counts consecutive unanswered strobe cycles; the access itself keeps going.
    always_comb begin
        wait_cnt_next = 32'd0;
        bus_err       = 1'b0;
        if (pending && !flush) begin
            if (wait_cnt_reg == TIMEOUT_CYCLES - 32'd1)
                bus_err = 1'b1;
            else
                wait_cnt_next = wait_cnt_reg + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wait_cnt_reg <= 32'd0;
        else
            wait_cnt_reg <= wait_cnt_next;
    end

    assign if_bus_err = bus_err;
`else
    // TIMEOUT_CYCLES only matters when the timeout counter is built.
    assign if_bus_err = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed testbench for ifu_fetch: zero-wait streaming, wait states, branch delay slot,
// flush drain, stall hold and the optional fetch timeout.
`timescale 1ns/1ps
module tb_ifu_fetch;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [29:0] new_pc = 30'h0;
    logic        br_taken = 1'b0;
    logic [29:0] br_addr = 30'h0;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic        if_bus_err;
    int          vectors = 0;
    int          miscompares = 0;

    ifu_fetch_if bus_if();

    ifu_fetch #(
        .RESET_VECTOR  (30'h0),
        .NOP_INSN      (32'h0),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .new_pc    (new_pc),
        .br_taken  (br_taken),
        .br_addr   (br_addr),
        .bus       (bus_if.master),
        .if_pc     (if_pc),
        .if_insn   (if_insn),
        .if_en     (if_en),
        .if_bus_err(if_bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] insn_of(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    assign bus_if.if_rd_data = insn_of(bus_if.if_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; bus_if.if_rdy_ = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // From S_IDLE: enter S_FETCH, then flush a completing access to land on pc.
    task automatic goto_pc(input logic [29:0] pc);
        tick();
        flush = 1'b1; new_pc = pc; bus_if.if_rdy_ = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (bus_if.if_as_ !== 1'b1) begin miscompares++; $display("FAIL reset_as: got %b expected 1", bus_if.if_as_); end
        vectors++; if (bus_if.if_addr !== 30'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 0", bus_if.if_addr); end
        vectors++; if (if_en !== 1'b0 || if_pc !== 30'h0 || if_insn !== 32'h0) begin miscompares++; $display("FAIL reset_ifid: got en=%b pc=%h insn=%h expected 0/0/0", if_en, if_pc, if_insn); end
        vectors++; if (if_bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", if_bus_err); end
        // asynchronous reset in the middle of a waiting access
        goto_pc(30'h3);
        bus_if.if_rdy_ = 1'b1;
        tick();
        vectors++; if (bus_if.if_as_ !== 1'b0) begin miscompares++; $display("FAIL async_pre_as: got %b expected 0", bus_if.if_as_); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (bus_if.if_as_ !== 1'b1 || if_en !== 1'b0) begin miscompares++; $display("FAIL async_reset: got as=%b en=%b expected 1/0", bus_if.if_as_, if_en); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        bus_if.if_rdy_ = 1'b0;
        vectors++; if (bus_if.if_as_ !== 1'b1) begin miscompares++; $display("FAIL idle_as: got %b expected 1", bus_if.if_as_); end
        tick();
        vectors++; if (bus_if.if_as_ !== 1'b0 || bus_if.if_addr !== 30'h0) begin miscompares++; $display("FAIL first_fetch: got as=%b addr=%h expected 0/0", bus_if.if_as_, bus_if.if_addr); end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (if_en !== 1'b1 || if_pc !== 30'(i) || if_insn !== insn_of(30'(i)) || bus_if.if_addr !== 30'(i + 1)) begin
                miscompares++;
                $display("FAIL stream_%0d: got en=%b pc=%h insn=%h addr=%h expected 1/%h/%h/%h", i, if_en, if_pc, if_insn, bus_if.if_addr, 30'(i), insn_of(30'(i)), 30'(i + 1));
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        goto_pc(30'h5);
        bus_if.if_rdy_ = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (bus_if.if_as_ !== 1'b0 || bus_if.if_addr !== 30'h5) begin miscompares++; $display("FAIL wait_bus_%0d: got as=%b addr=%h expected 0/5", i, bus_if.if_as_, bus_if.if_addr); end
            tick();
            vectors++; if (if_en !== 1'b0 || if_bus_err !== 1'b0) begin miscompares++; $display("FAIL wait_bubble_%0d: got en=%b err=%b expected 0/0", i, if_en, if_bus_err); end
        end
        bus_if.if_rdy_ = 1'b0;
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'h5 || if_insn !== insn_of(30'h5)) begin miscompares++; $display("FAIL wait_done: got en=%b pc=%h insn=%h expected 1/5/%h", if_en, if_pc, if_insn, insn_of(30'h5)); end
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'h6) begin miscompares++; $display("FAIL wait_next: got en=%b pc=%h expected 1/6", if_en, if_pc); end
    endtask

    task automatic test_branch();
        do_reset();
        goto_pc(30'h9);
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'h9) begin miscompares++; $display("FAIL br_in_id: got en=%b pc=%h expected 1/9", if_en, if_pc); end
        br_taken = 1'b1; br_addr = 30'h100; bus_if.if_rdy_ = 1'b1;
        tick();
        br_taken = 1'b0; bus_if.if_rdy_ = 1'b0;
        vectors++; if (if_en !== 1'b0 || bus_if.if_addr !== 30'ha) begin miscompares++; $display("FAIL br_wait: got en=%b addr=%h expected 0/a", if_en, bus_if.if_addr); end
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'ha || bus_if.if_addr !== 30'h100) begin miscompares++; $display("FAIL br_slot: got en=%b pc=%h addr=%h expected 1/a/100", if_en, if_pc, bus_if.if_addr); end
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'h100 || if_insn !== insn_of(30'h100)) begin miscompares++; $display("FAIL br_target: got en=%b pc=%h insn=%h expected 1/100/%h", if_en, if_pc, if_insn, insn_of(30'h100)); end
        tick();
        vectors++; if (if_pc !== 30'h101) begin miscompares++; $display("FAIL br_after: got pc=%h expected 101", if_pc); end
    endtask

    task automatic test_flush_drain();
        do_reset();
        goto_pc(30'h7);
        bus_if.if_rdy_ = 1'b1;
        tick();
        flush = 1'b1; new_pc = 30'h40;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++; if (bus_if.if_as_ !== 1'b0 || bus_if.if_addr !== 30'h7 || if_en !== 1'b0) begin miscompares++; $display("FAIL drain_hold_%0d: got as=%b addr=%h en=%b expected 0/7/0", i, bus_if.if_as_, bus_if.if_addr, if_en); end
            if (i == 0) tick();
        end
        bus_if.if_rdy_ = 1'b0;
        tick();
        vectors++; if (if_en !== 1'b0 || bus_if.if_as_ !== 1'b0 || bus_if.if_addr !== 30'h40) begin miscompares++; $display("FAIL drain_drop: got en=%b as=%b addr=%h expected 0/0/40", if_en, bus_if.if_as_, bus_if.if_addr); end
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'h40) begin miscompares++; $display("FAIL flush_target: got en=%b pc=%h expected 1/40", if_en, if_pc); end
    endtask

    task automatic test_stall();
        do_reset();
        goto_pc(30'hb);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (if_en !== 1'b1 || if_pc !== 30'hb || bus_if.if_as_ !== 1'b1) begin miscompares++; $display("FAIL stall_hold_%0d: got en=%b pc=%h as=%b expected 1/b/1", i, if_en, if_pc, bus_if.if_as_); end
        end
        stall = 1'b0;
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'hc || if_insn !== insn_of(30'hc)) begin miscompares++; $display("FAIL stall_release: got en=%b pc=%h insn=%h expected 1/c/%h", if_en, if_pc, if_insn, insn_of(30'hc)); end
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'hd) begin miscompares++; $display("FAIL stall_next: got en=%b pc=%h expected 1/d", if_en, if_pc); end
    endtask

    task automatic test_timeout();
        logic exp_err;
        do_reset();
        goto_pc(30'h20);
        bus_if.if_rdy_ = 1'b1;
        for (int k = 1; k <= 6; k++) begin
`ifdef IFU_BUS_TIMEOUT_EN
            exp_err = (k == 4);
`else
            exp_err = 1'b0;
`endif
            #3;
            vectors++; if (if_bus_err !== exp_err) begin miscompares++; $display("FAIL timeout_%0d: got %b expected %b", k, if_bus_err, exp_err); end
            tick();
        end
        bus_if.if_rdy_ = 1'b0;
        tick();
        vectors++; if (if_en !== 1'b1 || if_pc !== 30'h20) begin miscompares++; $display("FAIL timeout_done: got en=%b pc=%h expected 1/20", if_en, if_pc); end
    endtask

    initial begin
        bus_if.if_rdy_ = 1'b1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_flush_drain();
        test_stall();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
